// File: rtl/gc_csg_pkg.sv
// Shared types and helpers for the pipelined CSG one-hot selector.
// Used by mux_one_hot_csg_pipe and csg_chan_sel.
package gc_csg_pkg;

    // Classification of one channel's select vector.
    typedef enum logic [1:0] {
        SEL_ZERO  = 2'd0,
        SEL_ONE   = 2'd1,
        SEL_MULTI = 2'd2
    } sel_stat_e;

    // Width of the packed multi-channel output bus.
    function automatic int out_width(input int nch, input int nsig);
        return nch * nsig;
    endfunction

    // Map zero / power-of-two flags of a select onto its status.
    function automatic sel_stat_e sel_stat(
        input logic is_zero,
        input logic is_pow2
    );
        sel_stat_e st;
        if (is_zero) begin
            st = SEL_ZERO;
        end else if (is_pow2) begin
            st = SEL_ONE;
        end else begin
            st = SEL_MULTI;
        end
        return st;
    endfunction

endpackage

// File: rtl/csg_chan_sel.sv
// One selector channel: S1 masks the groups by the select and classifies it,
// S2 OR-reduces the masked groups. Optional macro: MUX_CSG_HOLD_LAST_EN.
module csg_chan_sel
    import gc_csg_pkg::*;
#(
    parameter int N = 3,
    parameter int M = 12
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           s1_en_i,
    input  logic           s2_en_i,
    input  logic [M*N-1:0] grp_i,
    input  logic [M-1:0]   sel_i,
    output logic           illegal_o,
    output logic [N-1:0]   res_o,
    output logic           err_o
);

    localparam logic [M-1:0] SEL_LSB = M'(1);

    logic [M*N-1:0] mask_d;
    logic [M*N-1:0] mask_q;
    sel_stat_e      stat_d;
    sel_stat_e      stat_q;
    logic [N-1:0]   res_d;
    logic [N-1:0]   res_q;
    logic           err_d;
    logic           err_q;

    // Keep group x only when select bit x is set; classify the select.
    always_comb begin
        mask_d = '0;
        for (int x = 0; x < M; x++) begin
            mask_d[x*N +: N] = grp_i[x*N +: N] & {N{sel_i[x]}};
        end
        stat_d = sel_stat(sel_i == '0,
                          (sel_i & (sel_i - SEL_LSB)) == '0);
    end

    assign illegal_o = (stat_d != SEL_ONE);

    // Stage 1 registers: masked groups and select status.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q <= '0;
            stat_q <= SEL_ZERO;
        end else if (s1_en_i) begin
            mask_q <= mask_d;
            stat_q <= stat_d;
        end
    end

    // OR-reduce the masked groups; multi-hot yields the legacy OR.
    always_comb begin
        res_d = '0;
        for (int x = 0; x < M; x++) begin
            res_d = res_d | mask_q[x*N +: N];
        end
`ifdef MUX_CSG_HOLD_LAST_EN
        if (stat_q == SEL_ZERO) begin
            res_d = res_q;
        end
`endif
        err_d = (stat_q != SEL_ONE);
    end

    // Stage 2 registers: channel result and its select error.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_q <= '0;
            err_q <= 1'b0;
        end else if (s2_en_i) begin
            res_q <= res_d;
            err_q <= err_d;
        end
    end

    assign res_o = res_q;
    assign err_o = err_q;

endmodule

// File: rtl/mux_one_hot_csg_pipe.sv
// Pipelined multi-channel CSG one-hot selector with valid/ready handshake
// and select-error tracking. Optional macro: MUX_CSG_HOLD_LAST_EN.
module mux_one_hot_csg_pipe
    import gc_csg_pkg::*;
#(
    parameter int NUM_OF_IC_SIGNALS        = 3,
    parameter int MAX_NO_OF_PROGRAM_BLOCKS = 12,
    parameter int NUM_OF_CHANNELS          = 2,
    parameter int ERR_CNT_W                = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic [MAX_NO_OF_PROGRAM_BLOCKS*NUM_OF_IC_SIGNALS-1:0] in,
    input  logic [NUM_OF_CHANNELS*MAX_NO_OF_PROGRAM_BLOCKS-1:0]   s,
    input  logic in_valid,
    output logic in_ready,
    output logic [out_width(NUM_OF_CHANNELS, NUM_OF_IC_SIGNALS)-1:0] out,
    output logic out_valid,
    input  logic out_ready,
    output logic [NUM_OF_CHANNELS-1:0] sel_err,
    output logic err_sticky,
    output logic [ERR_CNT_W-1:0] err_cnt,
    input  logic err_clr
);

    localparam int NSIG = NUM_OF_IC_SIGNALS;
    localparam int MAXB = MAX_NO_OF_PROGRAM_BLOCKS;
    localparam int NCH  = NUM_OF_CHANNELS;

    logic                 v1_d;
    logic                 v1_q;
    logic                 v2_d;
    logic                 v2_q;
    logic                 s1_adv;
    logic                 s2_adv;
    logic                 fire;
    logic                 s2_load;
    logic [NCH-1:0]       ill;
    logic                 err_hit;
    logic [ERR_CNT_W-1:0] cnt_d;
    logic [ERR_CNT_W-1:0] cnt_q;
    logic                 sticky_d;
    logic                 sticky_q;

    // Each stage advances when empty or when its downstream advances.
    always_comb begin
        s2_adv  = !v2_q || out_ready;
        s1_adv  = !v1_q || s2_adv;
        fire    = in_valid && s1_adv;
        s2_load = s2_adv && v1_q;
        v1_d    = s1_adv ? in_valid : v1_q;
        v2_d    = s2_adv ? v1_q : v2_q;
    end

    // Stage valid flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
        end
    end

    assign in_ready  = s1_adv;
    assign out_valid = v2_q;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        csg_chan_sel #(
            .N (NSIG),
            .M (MAXB)
        ) u_sel (
            .clk       (clk),
            .reset     (reset),
            .s1_en_i   (fire),
            .s2_en_i   (s2_load),
            .grp_i     (in),
            .sel_i     (s[c*MAXB +: MAXB]),
            .illegal_o (ill[c]),
            .res_o     (out[c*NSIG +: NSIG]),
            .err_o     (sel_err[c])
        );
    end

    // Saturating error count and sticky flag; a clear beats a same-cycle hit.
    always_comb begin
        err_hit  = fire && (|ill);
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        if (err_clr) begin
            cnt_d    = '0;
            sticky_d = 1'b0;
        end else if (err_hit) begin
            sticky_d = 1'b1;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + ERR_CNT_W'(1);
            end
        end
    end

    // Error status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end

    assign err_cnt    = cnt_q;
    assign err_sticky = sticky_q;

    // A stalled result must not change or disappear.
    a_stall_stable: assert property (
        @(posedge clk) disable iff (reset)
        out_valid && !out_ready |=>
            out_valid && $stable(out) && $stable(sel_err)
    );

    // The error counter never wraps.
    a_cnt_sat: assert property (
        @(posedge clk) disable iff (reset)
        (err_cnt == '1) && !err_clr |=> err_cnt == '1
    );

endmodule

// File: tb/tb_mux_one_hot_csg_pipe.sv
// Randomized self-checking bench for mux_one_hot_csg_pipe.
// Reference model: in-order transaction queue with per-item acceptance age.
module tb_mux_one_hot_csg_pipe;

    localparam int NS = 3;
    localparam int MB = 12;
    localparam int NC = 2;
    localparam int EW = 8;
    localparam int IW = MB * NS;
    localparam int SW = NC * MB;
    localparam int OW = NC * NS;
    localparam int CMAX = (1 << EW) - 1;
`ifdef MUX_CSG_HOLD_LAST_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [IW-1:0] in_v;
    logic [SW-1:0] s_v;
    logic          in_valid;
    logic          in_ready;
    logic [OW-1:0] out_v;
    logic          out_valid;
    logic          out_ready;
    logic [NC-1:0] sel_err;
    logic          err_sticky;
    logic [EW-1:0] err_cnt;
    logic          err_clr;

    always #5 clk = ~clk;

    mux_one_hot_csg_pipe #(
        .NUM_OF_IC_SIGNALS        (NS),
        .MAX_NO_OF_PROGRAM_BLOCKS (MB),
        .NUM_OF_CHANNELS          (NC),
        .ERR_CNT_W                (EW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in         (in_v),
        .s          (s_v),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out        (out_v),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sel_err    (sel_err),
        .err_sticky (err_sticky),
        .err_cnt    (err_cnt),
        .err_clr    (err_clr)
    );

    typedef struct {
        logic [IW-1:0] d;
        logic [SW-1:0] s;
        int            acc;
    } item_t;

    item_t         q[$];
    int            cyc;
    logic [NS-1:0] last [NC];
    int            m_cnt;
    bit            m_sticky;
    int            n_chk;
    int            n_fail;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit illegal(input logic [MB-1:0] sel);
        return $countones(sel) != 1;
    endfunction

    function automatic logic [NS-1:0] ch_res(input item_t it, input int c,
                                             input logic [NS-1:0] lst);
        logic [MB-1:0] sel;
        logic [NS-1:0] r;
        sel = it.s[c*MB +: MB];
        r = '0;
        if (sel == '0) begin
            r = HOLD ? lst : '0;
        end else begin
            for (int x = 0; x < MB; x++) begin
                if (sel[x]) r = r | it.d[x*NS +: NS];
            end
        end
        return r;
    endfunction

    function automatic logic [MB-1:0] onehot();
        return MB'(1) << $urandom_range(0, MB - 1);
    endfunction

    function automatic logic [MB-1:0] rand_sel();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7) return onehot();
        if (r == 7) return '0;
        return MB'($urandom());
    endfunction

    function automatic logic [IW-1:0] rand_in();
        return IW'({$urandom(), $urandom()});
    endfunction

    // Check the DUT against the model, then advance the model by one edge.
    task automatic step();
        bit            exp_rdy;
        bit            exp_ov;
        bit            hit;
        logic [OW-1:0] exp_out;
        logic [NC-1:0] exp_err;
        item_t         it;
        @(negedge clk);
        exp_rdy = (q.size() < 2) || out_ready;
        exp_ov  = (q.size() > 0) && ((cyc - q[0].acc) >= 2);
        chk("in_ready", in_ready, exp_rdy);
        chk("out_valid", out_valid, exp_ov);
        chk("err_cnt", err_cnt, m_cnt);
        chk("err_sticky", err_sticky, m_sticky);
        exp_out = '0;
        exp_err = '0;
        if (exp_ov) begin
            for (int c = 0; c < NC; c++) begin
                exp_out[c*NS +: NS] = ch_res(q[0], c, last[c]);
                exp_err[c] = illegal(q[0].s[c*MB +: MB]);
            end
            chk("out", out_v, exp_out);
            chk("sel_err", sel_err, exp_err);
        end
        if (reset) begin
            q.delete();
            m_cnt = 0;
            m_sticky = 1'b0;
            for (int c = 0; c < NC; c++) last[c] = '0;
        end else begin
            if (exp_ov && out_ready) begin
                void'(q.pop_front());
                for (int c = 0; c < NC; c++) last[c] = exp_out[c*NS +: NS];
            end
            hit = 1'b0;
            if (in_valid && exp_rdy) begin
                it.d = in_v;
                it.s = s_v;
                it.acc = cyc;
                q.push_back(it);
                for (int c = 0; c < NC; c++) begin
                    if (illegal(s_v[c*MB +: MB])) hit = 1'b1;
                end
            end
            if (err_clr) begin
                m_cnt = 0;
                m_sticky = 1'b0;
            end else if (hit) begin
                m_sticky = 1'b1;
                if (m_cnt < CMAX) m_cnt++;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    logic [IW-1:0] in_a;

    initial begin
        n_chk = 0;
        n_fail = 0;
        cyc = 0;
        m_cnt = 0;
        m_sticky = 1'b0;
        for (int c = 0; c < NC; c++) last[c] = '0;
        reset = 1'b1;
        in_valid = 1'b0;
        in_v = '0;
        s_v = '0;
        out_ready = 1'b1;
        err_clr = 1'b0;
        step();
        step();
        reset = 1'b0;
        chk("rst_out", out_v, 0);
        chk("rst_ov", out_valid, 0);
        chk("rst_serr", sel_err, 0);
        chk("rst_cnt", err_cnt, 0);
        chk("rst_rdy", in_ready, 1);

        // Single transfer with fixed data, two cycles of latency.
        in_v = 36'h123456789;
        s_v = {12'h800, 12'h001};
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t1_early", out_valid, 0);
        step();
        chk("t1_ov", out_valid, 1);
        chk("t1_out", out_v, 6'h01);
        chk("t1_serr", sel_err, 0);
        step();

        // Ten back-to-back legal transfers.
        for (int i = 0; i < 10; i++) begin
            in_v = rand_in();
            s_v = {onehot(), onehot()};
            in_valid = 1'b1;
            step();
            chk("t2_rdy", in_ready, 1);
        end
        in_valid = 1'b0;
        repeat (3) step();

        // Output stall with the input still offered.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_v = rand_in();
            s_v = {onehot(), onehot()};
            in_valid = 1'b1;
            step();
        end
        chk("t3_rdy", in_ready, 0);
        chk("t3_ov", out_valid, 1);
        out_ready = 1'b1;
        in_valid = 1'b0;
        repeat (4) step();

        // Multi-hot select on channel 0, then clear against a new error.
        in_v = rand_in();
        s_v = {onehot(), 12'h003};
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("t4_out", out_v[NS-1:0], in_v[2:0] | in_v[5:3]);
        chk("t4_serr", sel_err[0], 1);
        chk("t4_stk", err_sticky, 1);
        chk("t4_cnt", err_cnt, 1);
        s_v = {12'h000, onehot()};
        in_valid = 1'b1;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        in_valid = 1'b0;
        chk("t4_clr", err_cnt, 0);
        chk("t4_clrs", err_sticky, 0);
        repeat (2) step();

        // Counter saturation.
        for (int i = 0; i < 300; i++) begin
            in_v = rand_in();
            s_v = {12'h0F0, 12'h000};
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        chk("t5_sat", err_cnt, CMAX);
        repeat (2) step();

        // Zero-hot on channel 1 following a legal channel-1 result.
        in_a = rand_in();
        in_v = in_a;
        s_v = {12'h004, 12'h001};
        in_valid = 1'b1;
        step();
        in_v = rand_in();
        s_v = {12'h000, 12'h002};
        step();
        in_valid = 1'b0;
        step();
        chk("t6_ch1", out_v[2*NS-1:NS], HOLD ? in_a[8:6] : 3'b000);
        chk("t6_serr", sel_err, 2'b10);

        // Reset in the middle of traffic.
        for (int i = 0; i < 3; i++) begin
            in_v = rand_in();
            s_v = {onehot(), onehot()};
            in_valid = 1'b1;
            step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_rst_ov", out_valid, 0);
        chk("t6_rst_rdy", in_ready, 1);
        chk("t6_rst_cnt", err_cnt, 0);
        in_valid = 1'b0;
        step();

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            in_v = rand_in();
            s_v = {rand_sel(), rand_sel()};
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            err_clr = ($urandom_range(0, 29) == 0);
            reset = ($urandom_range(0, 149) == 0);
            step();
        end
        reset = 1'b0;
        err_clr = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
